gsim_residual_check: RTL and testbench
======================================

Name: gsim_residual_check

Overview:
- Downstream checker for the Gauss-Seidel solver. It snoops the 16-word b stream entering the solver and captures the 16-word x stream leaving it.
- It then recomputes b' = A·x with the solver's banded matrix (diag 20, ±1: -13, ±2: +6, ±3: -1, zero outside 0..15) and compares b' with the captured b.
- It sits beside the solver in the testbench/top and provides a hardware self-check of convergence.

Parameters:
- TOL, 1, max allowed |b' - b| (integer LSBs) for a row to pass
- N, 16, vector length; fixed at 16, other values unsupported

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_en  input  1  b beat valid (same wire driving the solver)
- b_in  input  16  signed integer b word
- out_valid  input  1  x beat valid from solver
- x_out  input  32  signed Q16.16 x word from solver
- rec_valid  output  1  reconstructed row valid
- rec_b  output  16  signed reconstructed b'[r], saturated
- rec_diff  output  16  signed rec_b - b[r], saturated
- done  output  1  one-cycle pulse after last row
- pass  output  1  frame result, held until next frame starts
- proto_err  output  1  sticky protocol violation flag

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; b/x buffers, counters and indices cleared. Reset mid-frame aborts with no done pulse.
- States: IDLE, B_CAP, X_CAP, COMPUTE, REPORT.
- IDLE: in_en=1 stores b_in as b[0], b_cnt=1, clears pass, goes to B_CAP.
- B_CAP: each in_en beat stores b[b_cnt], b_cnt++. After the 16th beat, go to X_CAP. Gaps between beats allowed.
- X_CAP: each out_valid beat stores x[x_cnt], x_cnt++. After the 16th beat, go to COMPUTE with r=0.
- COMPUTE: one row per cycle, r = 0..15, 16 cycles. After r=15, go to REPORT.
  - Row sum S = 20·x[r] - 13·(x[r-1]+x[r+1]) + 6·(x[r-2]+x[r+2]) - (x[r-3]+x[r+3]). Out-of-range taps are 0.
  - S is 40-bit signed; multiplies are shift-add.
  - rec_b = sat16((S + 2^15) >>> 16), i.e. round half toward +inf.
  - rec_diff = sat16(rec_b - b[r]), computed at 17 bits.
- Output timing: rec_valid/rec_b/rec_diff are registered, so row r appears the cycle after it is evaluated. This gives 16 consecutive rec_valid cycles. rec_b/rec_diff hold their last value when rec_valid=0.
- Pass accumulation: a frame pass flag starts at 1 on entering COMPUTE and is cleared by any row with |rec_diff| > TOL.
- REPORT (1 cycle): done=1; pass register loads the frame flag; then IDLE.
- Protocol errors: proto_err is set on out_valid in IDLE/B_CAP, or on in_en in X_CAP/COMPUTE/REPORT. The offending beat is ignored. proto_err is cleared only by reset.
- in_en and out_valid in the same cycle: each is handled per the current-state rule above. out_valid beyond 16 is treated as X_CAP exit, so later beats flag proto_err.
- Back-to-back frames: in_en in the cycle after REPORT (state IDLE) is accepted.

Optional Feature:
- Macro: GSIM_RESIDUAL_MAXERR_EN.
- Defined: adds output port max_err (16, unsigned), the largest |rec_diff| of the current frame.
  - Cleared on entering COMPUTE; updated each row.
  - Registered with the same timing as rec_diff; final value held alongside pass.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- All x = 0x00010000, b = {12,-1,5,4,4,4,4,4,4,4,4,4,4,5,-1,12} -> rec_b equals b on every row, rec_diff=0, done pulse 1 cycle after 16th rec_valid, pass=1.
- x[0]=0x00000800, others 0, b all 0 -> rec_b = {1,0,0,0,...0}, rec_diff[0]=1, pass=1 (TOL=1). Same with TOL=0 -> pass=0.
- x[5]=0x7FFF0000, others 0 -> rec_b[5]=32767 (saturated), rec_b[4]=rec_b[6]=-32768 (saturated), rec_b[3]=rec_b[7]=32767 (6·32767 saturated), rec_b[2]=rec_b[8]=-32767.
- Case 1 with b[7]=7 -> rec_diff[7]=-3, pass=0; with b[7]=5 -> rec_diff[7]=-1, pass=1.
- Reset asserted at COMPUTE row 8 -> outputs 0 immediately, no done pulse; next full frame completes normally.
- out_valid pulsed during B_CAP -> proto_err=1, beat ignored, frame still completes; proto_err stays 1 until reset.

Source files
------------

// File: rtl/gsim_residual_check.sv
// Residual checker for the Gauss-Seidel solver: captures b and x, recomputes b' = A*x row by row and flags mismatches.
// Define GSIM_RESIDUAL_MAXERR_EN to add the max_err output (largest |rec_diff| of the frame).
`timescale 1ns/1ps
module gsim_residual_check #(
    parameter int TOL = 1,
    parameter int N   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_en,
    input  logic signed [15:0] b_in,
    input  logic               out_valid,
    input  logic signed [31:0] x_out,
    output logic               rec_valid,
    output logic signed [15:0] rec_b,
    output logic signed [15:0] rec_diff,
    output logic               done,
    output logic               pass,
    output logic               proto_err
`ifdef GSIM_RESIDUAL_MAXERR_EN
    ,
    output logic        [15:0] max_err
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_B_CAP   = 3'd1;
    localparam logic [2:0] S_X_CAP   = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;
    localparam logic [3:0] LAST      = 4'(N - 1);

    logic [2:0]         r_state;
    logic [3:0]         r_b_cnt;
    logic [3:0]         r_x_cnt;
    logic [3:0]         r_row;
    logic signed [15:0] r_b [N];
    logic signed [31:0] r_x [N];
    logic               r_frame_ok;
    logic               r_rec_valid;
    logic signed [15:0] r_rec_b;
    logic signed [15:0] r_rec_diff;
    logic               r_done;
    logic               r_pass;
    logic               r_proto_err;
`ifdef GSIM_RESIDUAL_MAXERR_EN
    logic [15:0]        r_max_err;
`endif

    // Taps x[r-3..r+3]; index 3 is the diagonal, out-of-range taps read as zero.
    logic signed [31:0] w_tap [7];
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            w_tap[k] = '0;
            if ((int'(r_row) + k - 3 >= 0) && (int'(r_row) + k - 3 < N)) begin
                w_tap[k] = r_x[4'(int'(r_row) + k - 3)];
            end
        end
    end

    logic signed [39:0] w_c, w_p1, w_p2, w_p3, w_sum, w_q;
    assign w_c   = 40'(w_tap[3]);
    assign w_p1  = 40'(w_tap[2]) + 40'(w_tap[4]);
    assign w_p2  = 40'(w_tap[1]) + 40'(w_tap[5]);
    assign w_p3  = 40'(w_tap[0]) + 40'(w_tap[6]);
    assign w_sum = (w_c <<< 4) + (w_c <<< 2)
                 - ((w_p1 <<< 3) + (w_p1 <<< 2) + w_p1)
                 + ((w_p2 <<< 2) + (w_p2 <<< 1))
                 - w_p3;
    assign w_q   = (w_sum + 40'sd32768) >>> 16;

    logic signed [15:0] w_rec_b;
    logic signed [15:0] w_rec_diff;
    logic signed [16:0] w_diff17;
    logic        [16:0] w_abs;
    logic               w_row_ok;

    assign w_diff17 = 17'(w_rec_b) - 17'(r_b[r_row]);

    always_comb begin
        w_rec_b = w_q[15:0];
        if (w_q > 40'sd32767) begin
            w_rec_b = 16'sh7FFF;
        end else if (w_q < -40'sd32768) begin
            w_rec_b = 16'sh8000;
        end
        w_rec_diff = w_diff17[15:0];
        if (w_diff17 > 17'sd32767) begin
            w_rec_diff = 16'sh7FFF;
        end else if (w_diff17 < -17'sd32768) begin
            w_rec_diff = 16'sh8000;
        end
    end

    assign w_abs    = w_rec_diff[15] ? -17'(w_rec_diff) : 17'(w_rec_diff);
    assign w_row_ok = (w_abs <= 17'(TOL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_b_cnt     <= '0;
            r_x_cnt     <= '0;
            r_row       <= '0;
            r_frame_ok  <= 1'b0;
            r_rec_valid <= 1'b0;
            r_rec_b     <= '0;
            r_rec_diff  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_proto_err <= 1'b0;
`ifdef GSIM_RESIDUAL_MAXERR_EN
            r_max_err   <= '0;
`endif
            // NOTE: the b/x buffers are reset as well, so an aborted frame leaves no stale samples behind.
            for (int i = 0; i < N; i++) begin
                r_b[i] <= '0;
                r_x[i] <= '0;
            end
        end else begin
            r_rec_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (out_valid) r_proto_err <= 1'b1;
                    if (in_en) begin
                        r_b[0]  <= b_in;
                        r_b_cnt <= 4'd1;
                        r_pass  <= 1'b0;
                        r_state <= S_B_CAP;
                    end
                end
                S_B_CAP: begin
                    if (out_valid) r_proto_err <= 1'b1;
                    if (in_en) begin
                        r_b[r_b_cnt] <= b_in;
                        r_b_cnt      <= r_b_cnt + 4'd1;
                        if (r_b_cnt == LAST) begin
                            r_x_cnt <= '0;
                            r_state <= S_X_CAP;
                        end
                    end
                end
                S_X_CAP: begin
                    if (in_en) r_proto_err <= 1'b1;
                    if (out_valid) begin
                        r_x[r_x_cnt] <= x_out;
                        r_x_cnt      <= r_x_cnt + 4'd1;
                        if (r_x_cnt == LAST) begin
                            r_row      <= '0;
                            r_frame_ok <= 1'b1;
`ifdef GSIM_RESIDUAL_MAXERR_EN
                            r_max_err  <= '0;
`endif
                            r_state    <= S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (in_en) r_proto_err <= 1'b1;
                    r_rec_valid <= 1'b1;
                    r_rec_b     <= w_rec_b;
                    r_rec_diff  <= w_rec_diff;
                    r_frame_ok  <= r_frame_ok & w_row_ok;
`ifdef GSIM_RESIDUAL_MAXERR_EN
                    if (w_abs[15:0] > r_max_err) r_max_err <= w_abs[15:0];
`endif
                    r_row <= r_row + 4'd1;
                    if (r_row == LAST) r_state <= S_REPORT;
                end
                S_REPORT: begin
                    if (in_en) r_proto_err <= 1'b1;
                    r_done  <= 1'b1;
                    r_pass  <= r_frame_ok;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rec_valid = r_rec_valid;
    assign rec_b     = r_rec_b;
    assign rec_diff  = r_rec_diff;
    assign done      = r_done;
    assign pass      = r_pass;
    assign proto_err = r_proto_err;
`ifdef GSIM_RESIDUAL_MAXERR_EN
    assign max_err   = r_max_err;
`endif

endmodule

// File: tb/tb_gsim_residual_check.sv
// Self-checking bench for gsim_residual_check: behavioural row model, per-cycle compare process, directed and random frames.
`timescale 1ns/1ps
module tb_gsim_residual_check;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_en = 1'b0;
    logic               out_valid = 1'b0;
    logic signed [15:0] b_in = '0;
    logic signed [31:0] x_out = '0;

    logic               rec_valid, done, pass, proto_err;
    logic signed [15:0] rec_b, rec_diff;
    logic               rec_valid0, done0, pass0, proto_err0;
    logic signed [15:0] rec_b0, rec_diff0;
`ifdef GSIM_RESIDUAL_MAXERR_EN
    logic        [15:0] max_err, max_err0;
`endif

    always #5 clk = ~clk;

    gsim_residual_check #(.TOL(1), .N(16)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .out_valid(out_valid), .x_out(x_out),
        .rec_valid(rec_valid), .rec_b(rec_b), .rec_diff(rec_diff),
        .done(done), .pass(pass), .proto_err(proto_err)
`ifdef GSIM_RESIDUAL_MAXERR_EN
        , .max_err(max_err)
`endif
    );

    gsim_residual_check #(.TOL(0), .N(16)) dut0 (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .out_valid(out_valid), .x_out(x_out),
        .rec_valid(rec_valid0), .rec_b(rec_b0), .rec_diff(rec_diff0),
        .done(done0), .pass(pass0), .proto_err(proto_err0)
`ifdef GSIM_RESIDUAL_MAXERR_EN
        , .max_err(max_err0)
`endif
    );

    int checks = 0;
    int failures = 0;
    int frames_done = 0;
    int row_idx = 0;
    int run_len = 0;
    bit prev_rv = 1'b0;
    longint last_pass = 0, last_pass0 = 0;

    logic signed [15:0] fr_b [16];
    logic signed [31:0] fr_x [16];
    longint obs_b [16];
    longint obs_d [16];

    longint q_b[$], q_d[$], q_mx[$];
    bit     q_p1[$], q_p0[$];
    int     coef [4] = '{20, -13, 6, -1};
    int     c1b  [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Plain matrix-row product of the banded A with x, rounded half up and saturated.
    function automatic longint model_row(input int r);
        longint s = 0;
        for (int k = -3; k <= 3; k++) begin
            if (r + k >= 0 && r + k < 16)
                s += longint'(coef[k < 0 ? -k : k]) * longint'(fr_x[r + k]);
        end
        return sat16((s + 32768) >>> 16);
    endfunction

    task automatic model_push();
        bit ok1 = 1'b1, ok0 = 1'b1;
        longint mx = 0;
        for (int r = 0; r < 16; r++) begin
            longint rb, rd, ad;
            rb = model_row(r);
            rd = sat16(rb - longint'(fr_b[r]));
            ad = (rd < 0) ? -rd : rd;
            q_b.push_back(rb);
            q_d.push_back(rd);
            if (ad > 1) ok1 = 1'b0;
            if (ad > 0) ok0 = 1'b0;
            if (ad > mx) mx = ad;
        end
        q_p1.push_back(ok1);
        q_p0.push_back(ok0);
        q_mx.push_back(mx);
    endtask

    // Compare process: every cycle out of reset, DUT outputs against the model queues.
    always @(negedge clk) begin : cmp
        longint eb, ed, emx;
        bit ep1, ep0;
        if (!reset) begin
            if (done) begin
                check("done_after_last_row", (prev_rv && run_len == 16 && !rec_valid) ? 1 : 0, 1);
                check("done_tol0_instance", done0, 1);
                if (q_p1.size() == 0) begin
                    check("unexpected_done", 0, 1);
                end else begin
                    ep1 = q_p1.pop_front();
                    ep0 = q_p0.pop_front();
                    emx = q_mx.pop_front();
                    check("pass_tol1", pass, ep1);
                    check("pass_tol0", pass0, ep0);
`ifdef GSIM_RESIDUAL_MAXERR_EN
                    check("max_err", max_err, emx);
                    check("max_err_tol0", max_err0, emx);
`endif
                end
                last_pass  = pass;
                last_pass0 = pass0;
                frames_done++;
                row_idx = 0;
            end
            if (rec_valid) begin
                run_len = prev_rv ? run_len + 1 : 1;
                if (q_b.size() == 0) begin
                    check("unexpected_rec_valid", 0, 1);
                end else begin
                    eb = q_b.pop_front();
                    ed = q_d.pop_front();
                    check($sformatf("rec_b[%0d]", row_idx), rec_b, eb);
                    check($sformatf("rec_diff[%0d]", row_idx), rec_diff, ed);
                    check($sformatf("rec_b_tol0[%0d]", row_idx), rec_b0, eb);
                    if (row_idx < 16) begin
                        obs_b[row_idx] = rec_b;
                        obs_d[row_idx] = rec_diff;
                    end
                    row_idx++;
                end
            end
            prev_rv = rec_valid;
        end
    end

    task automatic beat_gap(input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // mode 0: clean, 1: out_valid pulse during B_CAP, 2: in_en pulse during X_CAP
    task automatic send_streams(input int mode, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            beat_gap(gaps);
            in_en = 1'b1;
            b_in  = fr_b[i];
            if (mode == 1 && i == 5) begin
                out_valid = 1'b1;
                x_out     = $urandom;
            end
            @(posedge clk);
            #1;
            in_en = 1'b0;
            out_valid = 1'b0;
        end
        if (mode == 1) check("proto_err_bcap", proto_err, 1);
        for (int i = 0; i < 16; i++) begin
            beat_gap(gaps);
            out_valid = 1'b1;
            x_out     = fr_x[i];
            if (mode == 2 && i == 3) begin
                in_en = 1'b1;
                b_in  = 16'($urandom);
            end
            @(posedge clk);
            #1;
            out_valid = 1'b0;
            in_en = 1'b0;
        end
        if (mode == 2) check("proto_err_xcap", proto_err, 1);
    endtask

    task automatic wait_done(input int start);
        for (int c = 0; c < 200 && frames_done == start; c++) begin
            @(negedge clk);
            #1;
        end
        if (frames_done == start) check("done_timeout", 0, 1);
    endtask

    task automatic run_frame(input int mode, input bit gaps);
        int start;
        start = frames_done;
        model_push();
        send_streams(mode, gaps);
        wait_done(start);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rec_valid"}, rec_valid, 0);
        check({tag, "_rec_b"}, rec_b, 0);
        check({tag, "_rec_diff"}, rec_diff, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_proto_err"}, proto_err, 0);
    endtask

    task automatic set_case1();
        for (int i = 0; i < 16; i++) begin
            fr_x[i] = 32'sh0001_0000;
            fr_b[i] = 16'(c1b[i]);
        end
    endtask

    task automatic set_random_frame();
        longint rb;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) fr_x[i] = $urandom;
            else fr_x[i] = int'($urandom_range(0, 1048575)) - 524288;
        end
        for (int i = 0; i < 16; i++) begin
            rb = model_row(i);
            if ($urandom_range(0, 5) == 0) rb = rb + longint'(int'($urandom_range(0, 6)) - 3);
            fr_b[i] = 16'(sat16(rb));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Case 1: all-ones x reproduces the row sums of A exactly.
        set_case1();
        run_frame(0, 1'b1);
        check("c1_rec_b0", obs_b[0], 12);
        check("c1_rec_b1", obs_b[1], -1);
        check("c1_rec_b2", obs_b[2], 5);
        check("c1_rec_b7", obs_b[7], 4);
        check("c1_rec_diff7", obs_d[7], 0);
        check("c1_pass", last_pass, 1);

        // Case 2: small impulse on x[0] rounds to 1 on row 0 only.
        for (int i = 0; i < 16; i++) begin
            fr_x[i] = '0;
            fr_b[i] = '0;
        end
        fr_x[0] = 32'sh0000_0800;
        run_frame(0, 1'b0);
        check("c2_rec_b0", obs_b[0], 1);
        check("c2_rec_b1", obs_b[1], 0);
        check("c2_rec_diff0", obs_d[0], 1);
        check("c2_pass_tol1", last_pass, 1);
        check("c2_pass_tol0", last_pass0, 0);

        // Case 3: saturation of rec_b around a huge x[5].
        for (int i = 0; i < 16; i++) begin
            fr_x[i] = '0;
            fr_b[i] = '0;
        end
        fr_x[5] = 32'sh7FFF_0000;
        run_frame(0, 1'b0);
        check("c3_rec_b5", obs_b[5], 32767);
        check("c3_rec_b4", obs_b[4], -32768);
        check("c3_rec_b6", obs_b[6], -32768);
        check("c3_rec_b3", obs_b[3], 32767);
        check("c3_rec_b7", obs_b[7], 32767);
        check("c3_rec_b2", obs_b[2], -32767);
        check("c3_rec_b8", obs_b[8], -32767);

        // Case 4: tolerance edge on row 7, frames sent back to back.
        set_case1();
        fr_b[7] = 16'sd7;
        run_frame(0, 1'b0);
        check("c4a_rec_diff7", obs_d[7], -3);
        check("c4a_pass", last_pass, 0);
        fr_b[7] = 16'sd5;
        run_frame(0, 1'b0);
        check("c4b_rec_diff7", obs_d[7], -1);
        check("c4b_pass", last_pass, 1);

        // Abort a frame with reset while row 8 is being evaluated.
        set_case1();
        model_push();
        send_streams(0, 1'b0);
        for (int c = 0; c < 100 && row_idx < 8; c++) begin
            @(negedge clk);
            #1;
        end
        check("abort_reached_row8", row_idx, 8);
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        q_b.delete();
        q_d.delete();
        q_p1.delete();
        q_p0.delete();
        q_mx.delete();
        row_idx = 0;
        run_len = 0;
        prev_rv = 1'b0;
        start = frames_done;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", frames_done, start);
        set_case1();
        run_frame(0, 1'b1);
        check("after_abort_pass", last_pass, 1);

        // Random frames with gaps and back-to-back starts.
        for (int f = 0; f < 20; f++) begin
            set_random_frame();
            run_frame(0, f[0]);
        end
        check("no_proto_err_yet", proto_err, 0);

        // Protocol violations: ignored beats, sticky flag.
        set_random_frame();
        run_frame(1, 1'b0);
        set_random_frame();
        run_frame(2, 1'b1);
        set_random_frame();
        run_frame(0, 1'b0);
        check("proto_err_sticky", proto_err, 1);
        check("proto_err_tol0", proto_err0, 1);
        reset = 1'b1;
        #1;
        check("proto_err_cleared", proto_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("queues_drained", q_b.size() + q_p1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
